// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic (write and read sides).
package fifo_cdc_pkg;

    // Pointer words are carried at this width inside helper functions;
    // callers size-cast the result down to their own pointer width.
    localparam int unsigned ptr_word_width = 32;

    typedef logic [ptr_word_width-1:0] ptr_word_t;

    // FIFO depth D for a given log2 depth.
    function automatic int unsigned fifo_depth(input int unsigned depth_log2);
        return 32'd1 << depth_log2;
    endfunction

    // Pointer width W: one extra bit beyond the address to tell full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth_log2);
        return depth_log2 + 32'd1;
    endfunction

    // Binary to Gray; the argument is zero-extended, so any width up to
    // ptr_word_width works and the caller truncates the result.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the FIFO: producer handshake, RAM write port and the
// Gray pointers exchanged with the read domain.
interface fifo_wptr_full_if
    import fifo_cdc_pkg::*;
#(
    parameter int unsigned depth_log2_p = 4
);
    localparam int unsigned ptr_w = ptr_width(depth_log2_p);

    logic                    valid_i;
    logic                    ready_o;
    logic                    wen_o;
    logic [depth_log2_p-1:0] waddr_o;
    logic [ptr_w-1:0]        wptr_gray_o;
    logic [ptr_w-1:0]        rptr_gray_i;
    logic                    full_o;
    logic [ptr_w-1:0]        free_o;

    // The pointer/full block.
    modport slave (
        input  valid_i,
        input  rptr_gray_i,
        output ready_o,
        output wen_o,
        output waddr_o,
        output wptr_gray_o,
        output full_o,
        output free_o
    );

    // Producer plus read-domain pointer source.
    modport master (
        output valid_i,
        output rptr_gray_i,
        input  ready_o,
        input  wen_o,
        input  waddr_o,
        input  wptr_gray_o,
        input  full_o,
        input  free_o
    );

endinterface

// File: rtl/gray2bin.sv
// Gray to binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int unsigned width_p = 5
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] bin_o
);

    // Prefix XOR from the MSB down, written as a reduction to avoid a comb self-loop.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < int'(width_p); i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag logic of the dual-clock FIFO.
// Keeps the binary/Gray write pointers, synchronizes the read Gray pointer
// into clk_i and derives full and free-slot count from registered state only.
module fifo_wptr_full
    import fifo_cdc_pkg::*;
#(
    parameter int unsigned depth_log2_p  = 4,
    parameter int unsigned sync_stages_p = 2
) (
    input logic              clk_i,
    input logic              reset_i,
    fifo_wptr_full_if.slave  wr
);

    localparam int unsigned ptr_w = ptr_width(depth_log2_p);
    localparam int unsigned depth = fifo_depth(depth_log2_p);
    localparam logic [ptr_w-1:0] depth_ptr = ptr_w'(depth);

    logic [ptr_w-1:0] wbin_q;
    logic [ptr_w-1:0] wbin_d;
    logic [ptr_w-1:0] wgray_q;
    logic [ptr_w-1:0] wgray_d;
    logic [ptr_w-1:0] rbin_s;
    logic [ptr_w-1:0] used_s;
    logic [ptr_w-1:0] free_s;
    logic             full_s;
    logic             accept_s;

    // Stage 0 takes the asynchronous input; the last stage feeds the converter.
    logic [sync_stages_p-1:0][ptr_w-1:0] rsync_q;

    gray2bin #(
        .width_p (ptr_w)
    ) u_rptr_g2b (
        .gray_i (rsync_q[sync_stages_p-1]),
        .bin_o  (rbin_s)
    );

    // Occupancy against the synchronized read pointer; a stale read pointer
    // can only make this larger, so full is conservative.
    always_comb begin
        used_s = wbin_q - rbin_s;
        full_s = (used_s == depth_ptr);
        free_s = depth_ptr - used_s;
    end

    // Next pointer values; Gray is taken from the next binary so the output is a pure flop.
    always_comb begin
        accept_s = wr.valid_i & ~full_s;
        wbin_d   = wbin_q + ptr_w'(accept_s);
        wgray_d  = ptr_w'(bin2gray(ptr_word_t'(wbin_d)));
    end

    // Write pointer registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wbin_q  <= '0;
            wgray_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
        end
    end

    // Read-pointer synchronizer chain.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rsync_q <= '0;
        end else begin
            rsync_q <= {rsync_q[sync_stages_p-2:0], wr.rptr_gray_i};
        end
    end

    // Only wen_o sees valid_i combinationally; the rest come from flops.
    always_comb begin
        wr.ready_o     = ~full_s;
        wr.wen_o       = accept_s;
        wr.waddr_o     = wbin_q[depth_log2_p-1:0];
        wr.wptr_gray_o = wgray_q;
        wr.full_o      = full_s;
        wr.free_o      = free_s;
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full at D = 4, W = 3, two sync stages.
// The reference model counts writes and reads as plain integers and delays
// the read count by the synchronizer depth.
module tb_fifo_wptr_full;

    logic clk;
    logic rst;

    int total;
    int bad;

    // Reference model state
    int wr_cnt;
    int rd_cnt;
    int rd_pipe[$];

    logic       chk_gray;
    logic       saw_wrap;
    logic [2:0] prev_gray;

    fifo_wptr_full_if #(.depth_log2_p(2)) bus ();

    fifo_wptr_full #(
        .depth_log2_p  (2),
        .sync_stages_p (2)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .wr      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] to_gray(input int n);
        logic [2:0] b;
        b = n[2:0];
        return b ^ (b >> 1);
    endfunction

    function automatic int m_used();
        return wr_cnt - rd_pipe[0];
    endfunction

    task automatic model_reset();
        wr_cnt  = 0;
        rd_cnt  = 0;
        rd_pipe = '{0, 0};
    endtask

    // Drive one cycle of stimulus from a negedge, advance the model at the
    // posedge, and return at the following negedge.
    task automatic tick(input logic v, input int rd, output logic obs_wen, output logic exp_wen);
        bus.valid_i     = v;
        rd_cnt          = rd;
        bus.rptr_gray_i = to_gray(rd);
        #1;
        obs_wen = bus.wen_o;
        exp_wen = v && (m_used() != 4);
        @(posedge clk);
        if (exp_wen) wr_cnt++;
        rd_pipe.push_back(rd);
        void'(rd_pipe.pop_front());
        @(negedge clk);
    endtask

    // Every change of the Gray write pointer must flip exactly one bit.
    always @(negedge clk) begin
        if (chk_gray) begin
            if (bus.wptr_gray_o !== prev_gray) begin
                total++;
                if ($countones(bus.wptr_gray_o ^ prev_gray) != 1) begin
                    bad++;
                    $display("FAIL gray_one_bit: got %b after %b, required a single-bit step",
                             bus.wptr_gray_o, prev_gray);
                end
                if (prev_gray == 3'b100 && bus.wptr_gray_o == 3'b000) saw_wrap = 1'b1;
            end
            prev_gray = bus.wptr_gray_o;
        end
    end

    task automatic test_reset();
        logic ow, ew;
        total++;
        if (bus.wptr_gray_o !== 3'b000 || bus.waddr_o !== 2'd0 || bus.full_o !== 1'b0
            || bus.free_o !== 3'd4 || bus.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_init: gray=%b waddr=%0d full=%b free=%0d ready=%b, required 000 0 0 4 1",
                     bus.wptr_gray_o, bus.waddr_o, bus.full_o, bus.free_o, bus.ready_o);
        end
        tick(1'b1, 0, ow, ew);
        tick(1'b1, 0, ow, ew);
        total++;
        if (bus.waddr_o !== 2'd2 || bus.wptr_gray_o !== 3'b011) begin
            bad++;
            $display("FAIL reset_prewrite: waddr=%0d gray=%b, required 2 011",
                     bus.waddr_o, bus.wptr_gray_o);
        end
        // Asynchronous reset in the middle of the low phase
        #2;
        bus.valid_i = 1'b1;
        rst         = 1'b1;
        #1;
        total++;
        if (bus.wptr_gray_o !== 3'b000 || bus.waddr_o !== 2'd0 || bus.full_o !== 1'b0
            || bus.free_o !== 3'd4) begin
            bad++;
            $display("FAIL reset_async: gray=%b waddr=%0d full=%b free=%0d, required 000 0 0 4",
                     bus.wptr_gray_o, bus.waddr_o, bus.full_o, bus.free_o);
        end
        total++;
        if (bus.ready_o !== 1'b1 || bus.wen_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_wen: ready=%b wen=%b, required 1 1",
                     bus.ready_o, bus.wen_o);
        end
        @(negedge clk);
        total++;
        if (bus.waddr_o !== 2'd0 || bus.wptr_gray_o !== 3'b000) begin
            bad++;
            $display("FAIL reset_hold: waddr=%0d gray=%b, required 0 000",
                     bus.waddr_o, bus.wptr_gray_o);
        end
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        logic       ow, ew;
        logic [2:0] g_tab [5];
        logic [1:0] a_tab [5];
        logic       w_tab [5];
        g_tab = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b110};
        a_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        w_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.valid_i = 1'b1;
            #1;
            total++;
            if (bus.waddr_o !== a_tab[i]) begin
                bad++;
                $display("FAIL fill_waddr[%0d]: got %0d, required %0d", i, bus.waddr_o, a_tab[i]);
            end
            tick(1'b1, 0, ow, ew);
            total++;
            if (ow !== w_tab[i] || ew !== w_tab[i]) begin
                bad++;
                $display("FAIL fill_wen[%0d]: got %b (model %b), required %b", i, ow, ew, w_tab[i]);
            end
            total++;
            if (bus.wptr_gray_o !== g_tab[i]) begin
                bad++;
                $display("FAIL fill_gray[%0d]: got %b, required %b", i, bus.wptr_gray_o, g_tab[i]);
            end
        end
        total++;
        if (bus.full_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.free_o !== 3'd0
            || bus.waddr_o !== 2'd0 || wr_cnt != 4) begin
            bad++;
            $display("FAIL fill_full: full=%b ready=%b free=%0d waddr=%0d model_wr=%0d, required 1 0 0 0 4",
                     bus.full_o, bus.ready_o, bus.free_o, bus.waddr_o, wr_cnt);
        end
    endtask

    task automatic test_drain();
        logic ow, ew;
        tick(1'b0, 1, ow, ew);
        total++;
        if (bus.full_o !== 1'b1) begin
            bad++;
            $display("FAIL drain_edge1: full=%b, required 1", bus.full_o);
        end
        tick(1'b0, 1, ow, ew);
        total++;
        if (bus.full_o !== 1'b0 || bus.free_o !== 3'd1 || bus.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL drain_edge2: full=%b free=%0d ready=%b, required 0 1 1",
                     bus.full_o, bus.free_o, bus.ready_o);
        end
    endtask

    task automatic test_simultaneous();
        logic ow, ew;
        int   exp_free;
        tick(1'b0, 2, ow, ew);
        tick(1'b0, 2, ow, ew);
        total++;
        if (bus.free_o !== 3'd2) begin
            bad++;
            $display("FAIL simul_setup: free=%0d, required 2", bus.free_o);
        end
        tick(1'b1, 3, ow, ew);
        total++;
        if (ow !== 1'b1) begin
            bad++;
            $display("FAIL simul_wen: got %b, required 1", ow);
        end
        for (int i = 0; i < 2; i++) begin
            exp_free = 4 - m_used();
            total++;
            if (int'(bus.free_o) != exp_free || bus.free_o > 3'd2) begin
                bad++;
                $display("FAIL simul_free[%0d]: got %0d, required %0d and at most 2",
                         i, bus.free_o, exp_free);
            end
            tick(1'b0, 3, ow, ew);
        end
        total++;
        if (bus.free_o !== 3'd2) begin
            bad++;
            $display("FAIL simul_settle: free=%0d, required 2", bus.free_o);
        end
    endtask

    task automatic test_wrap();
        logic ow, ew;
        logic v;
        int   rd;
        int   acc;
        int   cyc;
        acc       = 0;
        cyc       = 0;
        saw_wrap  = 1'b0;
        prev_gray = bus.wptr_gray_o;
        chk_gray  = 1'b1;
        while (acc < 20 && cyc < 200) begin
            v  = (($urandom % 4) != 0);
            rd = rd_cnt;
            if (rd_cnt < wr_cnt && ($urandom % 2) == 1) rd = rd_cnt + 1;
            tick(v, rd, ow, ew);
            if (ew) acc++;
            cyc++;
            total++;
            if (ow !== ew) begin
                bad++;
                $display("FAIL wrap_wen[%0d]: got %b, required %b", cyc, ow, ew);
            end
            total++;
            if (bus.full_o !== (m_used() == 4) || bus.ready_o !== (m_used() != 4)
                || int'(bus.free_o) != 4 - m_used()) begin
                bad++;
                $display("FAIL wrap_flags[%0d]: full=%b ready=%b free=%0d, required used=%0d",
                         cyc, bus.full_o, bus.ready_o, bus.free_o, m_used());
            end
            total++;
            if (bus.wptr_gray_o !== to_gray(wr_cnt) || int'(bus.waddr_o) != wr_cnt % 4) begin
                bad++;
                $display("FAIL wrap_ptr[%0d]: gray=%b waddr=%0d, required %b %0d",
                         cyc, bus.wptr_gray_o, bus.waddr_o, to_gray(wr_cnt), wr_cnt % 4);
            end
        end
        chk_gray = 1'b0;
        total++;
        if (acc < 20) begin
            bad++;
            $display("FAIL wrap_budget: accepted %0d writes in %0d cycles, required 20", acc, cyc);
        end
        total++;
        if (saw_wrap !== 1'b1) begin
            bad++;
            $display("FAIL wrap_seen: saw_wrap=%b, required 1", saw_wrap);
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        chk_gray        = 1'b0;
        saw_wrap        = 1'b0;
        prev_gray       = 3'b000;
        rst             = 1'b1;
        bus.valid_i     = 1'b0;
        bus.rptr_gray_i = 3'b000;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
